// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one 4-bit LFSR among NREQ requesters.
// Seeds the LFSR after reset, on software request, and after an all-zero lockup.
module rng_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter logic [3:0]  DEF_SEED = 4'h1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            seed_we,
  input  logic [3:0]      seed_val,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            rnd_valid,
  output logic [3:0]      rnd_data,
  output logic            busy,
  output logic            lockup_err
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : gen_bad_nreq
    $error("rng_arbiter: NREQ must be in 2..8");
  end
  if (DEF_SEED == 4'h0) begin : gen_bad_seed
    $error("rng_arbiter: DEF_SEED must be nonzero");
  end

  typedef enum logic [0:0] {StSeed, StRun} state_e;

  state_e            state_q, state_d;
  logic [3:0]        lfsr_q, lfsr_d;
  logic [3:0]        seed_q, seed_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic [3:0]        data_q, data_d;
  logic              lock_q, lock_d;

  logic              load;
  logic              win_found;
  logic [PtrW-1:0]   win_idx;
  logic [PtrW-1:0]   win_nxt;

  assign load = (state_q == StSeed);

  always_comb begin
    lfsr_d = load ? seed_q : {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  // First set request searching upward from rr_ptr with wrap-around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned cand;
      cand = (32'(rr_ptr_q) + k) % NREQ;
      if (!win_found && req[cand[PtrW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    int unsigned nxt;
    nxt     = (32'(win_idx) + 32'd1) % NREQ;
    win_nxt = nxt[PtrW-1:0];
  end

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = '0;
    valid_d  = 1'b0;
    data_d   = data_q;
    lock_d   = lock_q;
    case (state_q)
      StSeed: begin
        state_d = StRun;
      end
      StRun: begin
        if (lfsr_q == 4'h0) begin
          lock_d  = 1'b1;
          seed_d  = DEF_SEED;
          state_d = StSeed;
        end else if (seed_we) begin
          seed_d  = (seed_val == 4'h0) ? DEF_SEED : seed_val;
          state_d = StSeed;
        end else if (win_found) begin
          gnt_d    = NREQ'(1) << win_idx;
          valid_d  = 1'b1;
          data_d   = lfsr_q;
          rr_ptr_d = win_nxt;
        end
      end
      default: begin
        state_d = StSeed;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StSeed;
      lfsr_q   <= 4'h0;
      seed_q   <= DEF_SEED;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= 4'h0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      seed_q   <= seed_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      lock_q   <= lock_d;
    end
  end

  assign gnt        = gnt_q;
  assign rnd_valid  = valid_q;
  assign rnd_data   = data_q;
  assign busy       = (state_q != StRun);
  assign lockup_err = lock_q;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_valid_gnt  : assert property (@(posedge clk) disable iff (!rst_n) valid_q == (|gnt_q));
  a_busy_idle  : assert property (@(posedge clk) disable iff (!rst_n) busy |-> !valid_q);

endmodule

// File: tb/tb_rng_arbiter.sv
// Randomized bench for rng_arbiter with a behavioural reference model and
// directed literal checks for reset, sequence, reseed and lockup behaviour.
module tb_rng_arbiter;

  localparam int NREQ = 4;
  localparam logic [3:0] DEF_SEED = 4'h1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            seed_we;
  logic [3:0]      seed_val;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rnd_valid;
  logic [3:0]      rnd_data;
  logic            busy;
  logic            lockup_err;

  rng_arbiter #(.NREQ(NREQ), .DEF_SEED(DEF_SEED)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_we    (seed_we),
    .seed_val   (seed_val),
    .req        (req),
    .gnt        (gnt),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data),
    .busy       (busy),
    .lockup_err (lockup_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit force_q  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-cycle behaviour computed from the rules.
  logic [3:0]      m_q, m_seed, m_cur, m_data;
  int              m_ptr;
  bit              m_run, m_valid, m_lock;
  logic [NREQ-1:0] m_gnt;

  function automatic logic [3:0] lfsr_next(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = 4'h0; m_seed = DEF_SEED; m_ptr = 0; m_run = 1'b0;
      m_gnt = '0; m_valid = 1'b0; m_data = 4'h0; m_lock = 1'b0;
    end else begin
      m_cur   = force_q ? 4'h0 : m_q;
      m_gnt   = '0;
      m_valid = 1'b0;
      if (!m_run) begin
        m_q   = m_seed;
        m_run = 1'b1;
      end else begin
        m_q = lfsr_next(m_cur);
        if (m_cur == 4'h0) begin
          m_lock = 1'b1; m_seed = DEF_SEED; m_run = 1'b0;
        end else if (seed_we) begin
          m_seed = (seed_val == 4'h0) ? DEF_SEED : seed_val;
          m_run  = 1'b0;
        end else begin
          for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req[i] && !m_valid) begin
              m_gnt[i] = 1'b1; m_valid = 1'b1; m_data = m_cur;
              m_ptr = (i + 1) % NREQ;
            end
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("rnd_valid", 32'(rnd_valid), 32'(m_valid));
      chk("rnd_data", 32'(rnd_data), 32'(m_data));
      chk("busy", 32'(busy), 32'(!m_run));
      chk("lockup_err", 32'(lockup_err), 32'(m_lock));
    end
  end

  logic [3:0]      seq   [0:14];
  logic [NREQ-1:0] rr_g  [0:4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [NREQ-1:0] pat);
    rst_n = 1'b0; seed_we = 1'b0; seed_val = 4'h0; req = pat;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(rnd_valid), 32'h0);
    chk("rst_data", 32'(rnd_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_lock", 32'(lockup_err), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    int g0, g2, bad;
    seq  = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Single requester held: full LFSR sequence from DEF_SEED.
    do_reset(4'b0001);
    #1;
    chk("busy_before_e1", 32'(busy), 32'h1);
    tick();
    chk("busy_after_e1", 32'(busy), 32'h0);
    chk("no_gnt_e1", 32'(gnt), 32'h0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("seq_gnt", 32'(gnt), 32'h1);
      chk("seq_data", 32'(rnd_data), 32'(seq[k % 15]));
    end

    // All requesting: round robin with consecutive LFSR states.
    do_reset(4'b1111);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(rr_g[k]));
      chk("rr_data", 32'(rnd_data), 32'(seq[k]));
    end

    // Software reseed with 0xA, then with 0 (substitutes DEF_SEED).
    do_reset(4'b0001);
    tick(); tick(); tick();
    seed_we = 1'b1; seed_val = 4'hA;
    tick();
    chk("reseed_nogrant", 32'(gnt), 32'h0);
    chk("reseed_busy", 32'(busy), 32'h1);
    seed_we = 1'b0;
    tick();
    chk("reseed_run", 32'(busy), 32'h0);
    chk("reseed_nogrant2", 32'(gnt), 32'h0);
    tick(); chk("reseed_d0", 32'(rnd_data), 32'hA);
    tick(); chk("reseed_d1", 32'(rnd_data), 32'h5);
    tick(); chk("reseed_d2", 32'(rnd_data), 32'hB);
    seed_we = 1'b1; seed_val = 4'h0;
    tick();
    chk("zseed_busy", 32'(busy), 32'h1);
    seed_we = 1'b0;
    tick(); tick();
    chk("zseed_data", 32'(rnd_data), 32'h1);
    chk("zseed_lock", 32'(lockup_err), 32'h0);

    // Lockup recovery, then asynchronous reset while a grant is showing.
    force dut.lfsr_q = 4'h0;
    force_q = 1'b1;
    tick();
    chk("lock_set", 32'(lockup_err), 32'h1);
    chk("lock_nogrant", 32'(gnt), 32'h0);
    chk("lock_busy", 32'(busy), 32'h1);
    release dut.lfsr_q;
    force_q = 1'b0;
    tick();
    chk("lock_run", 32'(busy), 32'h0);
    tick();
    chk("lock_resume", 32'(rnd_data), 32'h1);
    chk("lock_sticky", 32'(lockup_err), 32'h1);
    chk("lock_gnt", 32'(gnt), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_valid", 32'(rnd_valid), 32'h0);
    chk("async_lock", 32'(lockup_err), 32'h0);
    chk("async_busy", 32'(busy), 32'h1);

    // Requesters 0 and 2 drop on grant and re-raise a cycle later.
    do_reset(4'b0101);
    g0 = 0; g2 = 0; bad = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (gnt[1] || gnt[3]) bad++;
      if (gnt[0]) g0++;
      if (gnt[2]) g2++;
      req[0] = !gnt[0];
      req[2] = !gnt[2];
    end
    chk("alt_bad", 32'(bad), 32'h0);
    chk("alt_g0", 32'(g0 >= 5), 32'h1);
    chk("alt_g2", 32'(g2 >= 5), 32'h1);

    // Randomized traffic checked cycle by cycle against the model.
    do_reset(4'b0000);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (force_q) begin
        release dut.lfsr_q;
        force_q = 1'b0;
      end
      seed_we  = ($urandom_range(39) == 0);
      seed_val = 4'($urandom_range(15));
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(2) == 0) req[i] = 1'b1;
      end
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(599) == 0) begin
        rst_n = 1'b0;
      end else if (!busy && $urandom_range(299) == 0) begin
        force dut.lfsr_q = 4'h0;
        force_q = 1'b1;
      end
    end
    @(negedge clk);
    if (force_q) begin
      release dut.lfsr_q;
      force_q = 1'b0;
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
